seven_seg_scan_driver: RTL and testbench

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

---
 rtl/seven_seg_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment display driver: shadows a hex word, scans one digit per
// refresh period, and drives registered segment/decimal-point/anode lines.
module seven_seg_scan_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter bit          COMMON_ANODE = 1'b0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        en,
  input  logic                                        load,
  input  logic [4*DIGITS-1:0]                         din,
  input  logic [DIGITS-1:0]                           dp_in,
  input  logic                                        blank_lz,
  output logic [6:0]                                  seg,
  output logic                                        dp,
  output logic [DIGITS-1:0]                           an,
  output logic [(DIGITS > 1 ? $clog2(DIGITS) : 1)-1:0] digit_idx,
  output logic                                        out_en,
  output logic                                        frame_done
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = $clog2(REFRESH_DIV);

  logic [4*DIGITS-1:0] din_q;
  logic [DIGITS-1:0]   dp_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                frame_q, frame_d;
  logic                out_en_q;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q_out, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                cnt_term, idx_last;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank;
  logic [DIGITS-1:0]   an_onehot;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_above;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      4'hF: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Shadow registers load regardless of en so data can be staged while dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q <= '0;
      dp_q  <= '0;
    end else if (load) begin
      din_q <= din;
      dp_q  <= dp_in;
    end
  end

  always_comb begin
    cnt_term = (cnt_q == CntW'(REFRESH_DIV - 1));
    idx_last = (idx_q == IdxW'(DIGITS - 1));
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    frame_d  = 1'b0;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_term) begin
      cnt_d   = '0;
      idx_d   = idx_last ? '0 : idx_q + 1'b1;
      frame_d = idx_last;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Digit k is blank when it and every more significant nibble are zero; digit 0 never is.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (din_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_nib      = din_q[4*k +: 4];
        cur_dp       = dp_q[k];
        cur_blank    = blank_lz & lz_mask[k];
        an_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    an_d  = '0;
    if (en) begin
      an_d = an_onehot;
      if (!cur_blank) begin
        seg_d = hex7(cur_nib);
        dp_d  = cur_dp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      frame_q  <= 1'b0;
      out_en_q <= 1'b0;
      seg_q    <= '0;
      dp_q_out <= 1'b0;
      an_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      out_en_q <= en;
      seg_q    <= seg_d;
      dp_q_out <= dp_d;
      an_q     <= an_d;
    end
  end

  // Registers hold logical (active-high) levels; polarity is applied only at the pins.
  assign seg        = seg_q ^ {7{COMMON_ANODE}};
  assign dp         = dp_q_out ^ COMMON_ANODE;
  assign an         = an_q ^ {DIGITS{COMMON_ANODE}};
  assign digit_idx  = idx_q;
  assign out_en     = out_en_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: DIGITS=4, REFRESH_DIV=4, both polarities.
module tb_seven_seg_scan_driver;

  localparam logic [6:0] HEX [0:15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic        clk, rst, en, load, blank_lz;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [6:0]  seg, seg_ca;
  logic        dp, dp_ca, out_en, out_en_ca, frame_done, frame_done_ca;
  logic [3:0]  an, an_ca;
  logic [1:0]  digit_idx, digit_idx_ca;

  int vectors = 0;
  int miscompares = 0;

  seven_seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .COMMON_ANODE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx),
    .out_en(out_en), .frame_done(frame_done)
  );

  seven_seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .COMMON_ANODE(1'b1)) dut_ca (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_ca), .dp(dp_ca), .an(an_ca), .digit_idx(digit_idx_ca),
    .out_en(out_en_ca), .frame_done(frame_done_ca)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads the shadows with en low for one edge, then raises en; the next edge is scan edge 1.
  task automatic start_scan(input logic [15:0] d, input logic [3:0] p);
    din   = d;
    dp_in = p;
    load  = 1'b1;
    en    = 1'b0;
    tick();
    load  = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({an, seg, dp, digit_idx, out_en, frame_done} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_ca0: got an=%b seg=%b dp=%b idx=%0d oe=%b fd=%b want all zero",
               an, seg, dp, digit_idx, out_en, frame_done);
    end
    vectors++;
    if ({an_ca, seg_ca, dp_ca} !== 12'hfff) begin
      miscompares++;
      $display("FAIL reset_ca1: got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1",
               an_ca, seg_ca, dp_ca);
    end
    tick();
    #2 rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [15:0] pat;
    logic [3:0]  dpv, nib;
    logic [15:0] exp, got;
    int d, pulses;
    pat = 16'h1234;
    dpv = 4'b0101;
    pulses = 0;
    start_scan(pat, dpv);
    for (int n = 1; n <= 32; n++) begin
      tick();
      d   = ((n - 1) / 4) % 4;
      nib = 4'((pat >> (4 * d)) & 16'hf);
      exp = {4'(1 << d), HEX[nib], dpv[d], 2'((n / 4) % 4), (n % 16 == 0), 1'b1};
      got = {an, seg, dp, digit_idx, frame_done, out_en};
      if (frame_done) pulses++;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL scan_cycle%0d: got {an,seg,dp,idx,fd,oe}=%b want %b", n, got, exp);
      end
    end
    vectors++;
    if (pulses !== 2) begin
      miscompares++;
      $display("FAIL frame_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_blank();
    logic [6:0] exp_seg;
    logic       exp_dp;
    int d;
    blank_lz = 1'b1;
    start_scan(16'h0050, 4'b1111);
    for (int n = 1; n <= 16; n++) begin
      tick();
      d       = (n - 1) / 4;
      exp_seg = (d >= 2) ? 7'b0000000 : ((d == 1) ? 7'b1101101 : 7'b0111111);
      exp_dp  = (d < 2);
      vectors++;
      if ({an, seg, dp} !== {4'(1 << d), exp_seg, exp_dp}) begin
        miscompares++;
        $display("FAIL blank_lz1_digit%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 d, an, seg, dp, 4'(1 << d), exp_seg, exp_dp);
      end
    end
    blank_lz = 1'b0;
    start_scan(16'h0050, 4'b0000);
    for (int n = 1; n <= 16; n++) begin
      tick();
      d       = (n - 1) / 4;
      exp_seg = (d == 1) ? 7'b1101101 : 7'b0111111;
      vectors++;
      if (seg !== exp_seg) begin
        miscompares++;
        $display("FAIL blank_lz0_digit%0d: got seg=%b want %b", d, seg, exp_seg);
      end
    end
  endtask

  task automatic test_load_advance();
    start_scan(16'h1234, 4'b0000);
    for (int n = 1; n <= 3; n++) tick();
    din  = 16'hABCD;
    load = 1'b1;
    tick();
    load = 1'b0;
    vectors++;
    if ({an, seg} !== {4'b0001, HEX[4]}) begin
      miscompares++;
      $display("FAIL load_adv_old: got an=%b seg=%b want an=0001 seg=%b", an, seg, HEX[4]);
    end
    tick();
    vectors++;
    if ({an, seg} !== {4'b0010, HEX[12]}) begin
      miscompares++;
      $display("FAIL load_adv_new: got an=%b seg=%b want an=0010 seg=%b", an, seg, HEX[12]);
    end
  endtask

  task automatic test_en_drop();
    start_scan(16'h1234, 4'b0000);
    for (int n = 1; n <= 9; n++) tick();
    vectors++;
    if ({an, seg} !== {4'b0100, HEX[2]}) begin
      miscompares++;
      $display("FAIL en_drop_pre: got an=%b seg=%b want an=0100 seg=%b", an, seg, HEX[2]);
    end
    en = 1'b0;
    tick();
    vectors++;
    if ({an, seg, dp, out_en, frame_done, digit_idx} !== 15'd0) begin
      miscompares++;
      $display("FAIL en_drop_off: got an=%b seg=%b dp=%b oe=%b fd=%b idx=%0d want all zero",
               an, seg, dp, out_en, frame_done, digit_idx);
    end
    en = 1'b1;
    tick();
    vectors++;
    if ({an, seg, out_en, digit_idx} !== {4'b0001, HEX[4], 1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL en_resume: got an=%b seg=%b oe=%b idx=%0d want an=0001 seg=%b oe=1 idx=0",
               an, seg, out_en, digit_idx, HEX[4]);
    end
  endtask

  task automatic test_async_reset();
    start_scan(16'h1234, 4'b1111);
    for (int n = 1; n <= 6; n++) tick();
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({an, seg, dp, out_en, frame_done, digit_idx} !== 15'd0) begin
      miscompares++;
      $display("FAIL async_rst_ca0: got an=%b seg=%b dp=%b oe=%b fd=%b idx=%0d want all zero",
               an, seg, dp, out_en, frame_done, digit_idx);
    end
    vectors++;
    if ({an_ca, seg_ca, dp_ca} !== 12'hfff) begin
      miscompares++;
      $display("FAIL async_rst_ca1: got an=%b seg=%b dp=%b want all ones", an_ca, seg_ca, dp_ca);
    end
    tick();
    #2 rst = 1'b0;
    tick();
    vectors++;
    if ({an, seg, dp, digit_idx} !== {4'b0001, 7'b0111111, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL rst_restart: got an=%b seg=%b dp=%b idx=%0d want an=0001 seg=0111111 dp=0 idx=0",
               an, seg, dp, digit_idx);
    end
  endtask

  task automatic test_common_anode();
    blank_lz = 1'b0;
    start_scan(16'h0008, 4'b0000);
    tick();
    vectors++;
    if ({an_ca, seg_ca, dp_ca} !== {4'b1110, 7'b0000000, 1'b1}) begin
      miscompares++;
      $display("FAIL ca_digit0: got an=%b seg=%b dp=%b want an=1110 seg=0000000 dp=1",
               an_ca, seg_ca, dp_ca);
    end
    for (int n = 2; n <= 5; n++) tick();
    vectors++;
    if ({an_ca, seg_ca} !== {4'b1101, 7'b1000000}) begin
      miscompares++;
      $display("FAIL ca_digit1: got an=%b seg=%b want an=1101 seg=1000000", an_ca, seg_ca);
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    blank_lz = 1'b0;
    din      = '0;
    dp_in    = '0;
    test_reset();
    test_scan();
    test_blank();
    test_load_advance();
    test_en_drop();
    test_async_reset();
    test_common_anode();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
